// File: rtl/tube_arb_pkg.sv
// tube_arb_pkg: shared state encoding, tube addresses and default starvation limit for tube_write_arbiter
package tube_arb_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_e;
  localparam logic [2:0] TUBE_ADDR_MAIN = 3'd0;
  localparam logic [2:0] TUBE_ADDR_TUBE2 = 3'd4;
  localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/tube_arb_starve.sv
// tube_arb_starve: saturating count of requester-0 grants made while requester 1 waits
module tube_arb_starve
  import tube_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic grant0,
  input  logic grant1,
  input  logic req1,
  output logic limit_hit
);
  logic [3:0] cnt_q, cnt_d;
  assign limit_hit = cnt_q == 4'(LIMIT);
  always_comb cnt_d = (grant1 || !req1) ? 4'd0 : (grant0 && !limit_hit) ? cnt_q + 4'd1 : cnt_q;
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/tube_write_arbiter.sv
// tube_write_arbiter: two-requester tube write-port arbiter; TUBE_ARB_PROTECT_EN keeps requester 1 off the main tube word
module tube_write_arbiter
  import tube_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0,
  input  logic [2:0]  addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  input  logic        req1,
  input  logic [2:0]  addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic        tube_we,
  output logic [2:0]  tube_addr,
  output logic [31:0] tube_wd
);
  state_e state_q, state_d;
  logic we_q, we_d, ack0_q, ack0_d, ack1_q, ack1_d;
  logic [2:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic limit_hit, grant0, grant1, req1_writable, wr_en;
`ifdef TUBE_ARB_PROTECT_EN
  assign req1_writable = addr1 >= TUBE_ADDR_TUBE2;
`else
  assign req1_writable = 1'b1;
`endif
  tube_arb_starve #(.LIMIT(STARVE_LIMIT)) u_starve (
    .CLK(CLK),
    .RST(RST),
    .grant0(grant0),
    .grant1(grant1),
    .req1(req1),
    .limit_hit(limit_hit)
  );
  always_comb begin
    grant1 = state_q == ST_IDLE && req1 && (!req0 || limit_hit);
    grant0 = state_q == ST_IDLE && req0 && !grant1;
    wr_en = grant0 || (grant1 && req1_writable);
    state_d = (grant0 || grant1) ? ST_ISSUE : ST_IDLE;
    we_d = wr_en;
    ack0_d = grant0;
    ack1_d = grant1;
    addr_d = !wr_en ? addr_q : grant1 ? addr1 : addr0;
    wd_d = !wr_en ? wd_q : grant1 ? wdata1 : wdata0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      we_q <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      addr_q <= 3'd0;
      wd_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      addr_q <= addr_d;
      wd_q <= wd_d;
    end
  end
  assign tube_we = we_q;
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign tube_addr = addr_q;
  assign tube_wd = wd_q;
endmodule

// File: tb/tb_tube_write_arbiter.sv
// tb_tube_write_arbiter: directed and randomized checks of tube_write_arbiter against a write-slot model
module tb_tube_write_arbiter;
  localparam int LIMIT = 4;
  logic CLK = 1'b0, RST = 1'b1, req0 = 1'b0, req1 = 1'b0;
  logic [2:0] addr0 = 3'd0, addr1 = 3'd0;
  logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0;
  logic ack0, ack1, tube_we;
  logic [2:0] tube_addr;
  logic [31:0] tube_wd;
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  tube_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .tube_we(tube_we), .tube_addr(tube_addr), .tube_wd(tube_wd)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic bit writable1(input logic [2:0] a);
`ifdef TUBE_ARB_PROTECT_EN
    return a >= 3'd4;
`else
    return 1'b1;
`endif
  endfunction
  // Model: a grant occupies a two-cycle slot; the waiting count decides when requester 1 jumps the queue.
  bit m_busy = 0, w1;
  int m_wait = 0;
  logic e_we = 0, e_a0 = 0, e_a1 = 0;
  logic [2:0] e_addr = 0;
  logic [31:0] e_wd = 0;
  always @(posedge CLK) begin
    if (RST) begin
      m_busy = 0; m_wait = 0;
      e_we = 0; e_a0 = 0; e_a1 = 0; e_addr = 0; e_wd = 0;
    end else if (m_busy) begin
      m_busy = 0; e_we = 0; e_a0 = 0; e_a1 = 0;
      if (!req1) m_wait = 0;
    end else begin
      w1 = req1 && (!req0 || m_wait == LIMIT);
      e_a1 = w1;
      e_a0 = req0 && !w1;
      m_busy = req0 || req1;
      e_we = e_a0 || (w1 && writable1(addr1));
      if (e_we) begin
        e_addr = w1 ? addr1 : addr0;
        e_wd = w1 ? wdata1 : wdata0;
      end
      m_wait = (w1 || !req1) ? 0 : (m_wait < LIMIT ? m_wait + 1 : LIMIT);
    end
  end
  always @(negedge CLK) begin
    chk("tube_we", tube_we, e_we);
    chk("ack0", ack0, e_a0);
    chk("ack1", ack1, e_a1);
    chk("tube_addr", tube_addr, e_addr);
    chk("tube_wd", tube_wd, e_wd);
    chk("ack_exclusive", ack0 & ack1, 0);
  end
  int got[$];
  int exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  initial begin
    req0 = 1; addr0 = 3'd3; wdata0 = 32'hCAFE0001;
    repeat (2) begin
      @(negedge CLK);
      chk("rst_we", tube_we, 0); chk("rst_ack0", ack0, 0); chk("rst_ack1", ack1, 0);
    end
    RST = 0;
    @(negedge CLK);
    chk("post_rst_we", tube_we, 1); chk("post_rst_ack0", ack0, 1); chk("post_rst_wd", tube_wd, 32'hCAFE0001);
    req0 = 0;
    @(negedge CLK);
    chk("post_rst_issue_we", tube_we, 0);
    req0 = 1; addr0 = 3'd0; wdata0 = 32'h12345678;
    @(negedge CLK);
    chk("single_we", tube_we, 1); chk("single_addr", tube_addr, 0);
    chk("single_wd", tube_wd, 32'h12345678); chk("single_ack0", ack0, 1);
    req0 = 0;
    @(negedge CLK);
    chk("single_we_low", tube_we, 0); chk("single_ack0_low", ack0, 0);
    req0 = 1; req1 = 1; addr0 = 3'd1; wdata0 = 32'h11; addr1 = 3'd6; wdata1 = 32'h66;
    @(negedge CLK);
    chk("cont_ack0", ack0, 1); chk("cont_ack1_first", ack1, 0);
    req0 = 0;
    @(negedge CLK);
    chk("cont_gap_ack1", ack1, 0);
    @(negedge CLK);
    chk("cont_ack1", ack1, 1); chk("cont_ack0_late", ack0, 0); chk("cont_wd", tube_wd, 32'h66);
    req1 = 0;
    repeat (2) @(negedge CLK);
    req0 = 1; req1 = 1; addr1 = 3'd5;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      chk("starve_we_pattern", tube_we, (k % 2 == 0) ? 1 : 0);
      if (ack0) got.push_back(0);
      if (ack1) got.push_back(1);
    end
    req0 = 0; req1 = 0;
    chk("starve_grant_count", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++) chk("starve_order", got[i], exp_order[i]);
    repeat (2) @(negedge CLK);
    req0 = 1; addr0 = 3'd2; wdata0 = 32'hA5A5;
    @(negedge CLK);
    chk("rsti_ack0", ack0, 1);
    RST = 1; req0 = 0;
    @(negedge CLK);
    chk("rsti_we", tube_we, 0); chk("rsti_ack0", ack0, 0); chk("rsti_wd", tube_wd, 0);
    RST = 0;
    @(negedge CLK);
    chk("rsti_no_extra", tube_we, 0);
    req0 = 1;
    @(negedge CLK);
    chk("rsth_ack0", ack0, 1);
    RST = 1;
    @(negedge CLK);
    chk("rsth_we", tube_we, 0);
    RST = 0;
    @(negedge CLK);
    chk("rsth_served", ack0, 1); chk("rsth_served_we", tube_we, 1);
    req0 = 0;
    @(negedge CLK);
    req1 = 1; addr1 = 3'd0; wdata1 = 32'hFFFFFFFF;
    @(negedge CLK);
    chk("prot_main_ack1", ack1, 1);
`ifdef TUBE_ARB_PROTECT_EN
    chk("prot_main_we", tube_we, 0);
`else
    chk("prot_main_we", tube_we, 1);
`endif
    req1 = 0;
    @(negedge CLK);
    req1 = 1; addr1 = 3'd4; wdata1 = 32'h0000000A;
    @(negedge CLK);
    chk("prot_t2_we", tube_we, 1); chk("prot_t2_wd", tube_wd, 32'h0000000A); chk("prot_t2_ack1", ack1, 1);
    req1 = 0;
    @(negedge CLK);
    for (int c = 0; c < 3000; c++) begin
      RST = $urandom_range(63) == 0;
      if (req0 && !e_a0) begin
        if ($urandom_range(15) == 0) req0 = 0;
      end else begin
        req0 = $urandom_range(1); addr0 = 3'($urandom); wdata0 = $urandom;
      end
      if (req1 && !e_a1) begin
        if ($urandom_range(15) == 0) req1 = 0;
      end else begin
        req1 = $urandom_range(3) != 0; addr1 = 3'($urandom); wdata1 = $urandom;
      end
      @(negedge CLK);
    end
    RST = 0; req0 = 0; req1 = 0;
    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tube_write_arbiter.md
Name: tube_write_arbiter

Overview:
- Shares the digital-tube display peripheral's write port (WE / WD / innerADDR) between two requesters.
- Requester 0 is the CPU store path from the system bridge. Requester 1 is an auxiliary hardware source, e.g. a UART echo or status reporter.
- Fixed priority to requester 0, with an anti-starvation limit for requester 1. Outputs are registered and each write is confirmed by a one-cycle ack.
- Sits between the bridge and the tube peripheral. The read path (RD) does not go through this block.

Parameters:
- STARVE_LIMIT, 4: number of consecutive requester-0 grants allowed while requester 1 is waiting. Legal range 1..15.

Ports:
- CLK  input  1  system clock
- RST  input  1  reset, synchronous, active-high
- req0  input  1  requester 0 (CPU) write request
- addr0  input  3  requester 0 tube inner address
- wdata0  input  32  requester 0 write data
- ack0  output  1  one-cycle pulse: requester 0 write issued
- req1  input  1  requester 1 (auxiliary) write request
- addr1  input  3  requester 1 tube inner address
- wdata1  input  32  requester 1 write data
- ack1  output  1  one-cycle pulse: requester 1 write issued
- tube_we  output  1  to peripheral WE
- tube_addr  output  3  to peripheral innerADDR
- tube_wd  output  32  to peripheral WD

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: state=IDLE, starve_cnt=0, and tube_we, ack0, ack1, tube_addr, tube_wd all 0.
- Handshake:
  - A requester holds req, addr and wdata stable until it sees its ack.
  - A requester may keep req high after ack; this is treated as a new write.
  - Dropping req before ack withdraws the request; this is legal and nothing is issued.
- Two-state FSM, IDLE and ISSUE:
  - In IDLE with no req: stay in IDLE. tube_we, ack0 and ack1 are 0.
  - In IDLE with any req: pick a winner, register its addr and wdata into tube_addr and tube_wd, set tube_we=1 and ack_winner=1, then go to ISSUE.
  - In ISSUE: tube_we, ack0 and ack1 return to 0 at that edge. No grant is made. Next state is IDLE unconditionally.
- Timing:
  - Latency is 1 cycle: req sampled at edge t gives tube_we and ack at t+1.
  - Maximum throughput is one write every 2 cycles.
  - The ISSUE cycle keeps a requester's held req from being granted twice.
- Winner selection:
  - Requester 1 wins if req1 is high and either req0 is low or starve_cnt == STARVE_LIMIT.
  - Otherwise requester 0 wins.
- starve_cnt, width 4:
  - Increments, saturating at STARVE_LIMIT, on a grant to requester 0 while req1 is high.
  - Clears on a grant to requester 1, or in any cycle where req1 is low.
- tube_addr and tube_wd keep their last values when tube_we=0.
- ack0 and ack1 are never both 1 in the same cycle.
- Reset mid-operation: RST high at any edge forces the reset values, discards any pending grant and produces no ack. A requester that still holds req is served after RST is released.
- Addresses 5..7 are passed through unchanged. The peripheral treats any address >= 4 as the tube2 byte.

Optional Feature:
- Macro: TUBE_ARB_PROTECT_EN.
- Defined: requester 1 writes with addr1 < 4 (the main tube word) are acked normally but tube_we stays 0. tube_addr and tube_wd are not updated, and starve_cnt is cleared as for a normal grant. Requester 1 may only change tube2.
- Undefined: both requesters may write every address.

Decomposition:
- Shared package tube_arb_pkg holds:
  - state encoding ST_IDLE=1'b0, ST_ISSUE=1'b1
  - TUBE_ADDR_MAIN=3'd0
  - TUBE_ADDR_TUBE2=3'd4
  - default STARVE_LIMIT
- One sub-module, tube_arb_starve: the saturating starvation counter. Inputs are CLK, RST, grant0, grant1 and req1. Output is the limit_hit flag.

Test Plan:
- Reset: hold RST for 2 cycles with req0=1 -> tube_we, ack0 and ack1 stay 0; the first write appears 1 cycle after RST drops.
- Single write: req0=1, addr0=0, wdata0=0x12345678 at edge t -> at t+1 tube_we=1, tube_addr=0, tube_wd=0x12345678, ack0=1; at t+2 tube_we=0 and ack0=0.
- Contention: req0 and req1 raised together, each dropped after its ack -> requester 0 is granted first and requester 1 two cycles later; never both acked.
- Starvation: STARVE_LIMIT=4, req0 and req1 held high continuously -> grant order is 0,0,0,0,1,0,0,0,0,1 with tube_we high every second cycle.
- Reset in ISSUE: RST asserted at the edge following a grant -> tube_we, ack0 and ack1 are 0 from that edge; no extra write after release unless req is still held.
- Protect feature with TUBE_ARB_PROTECT_EN defined:
  - req1, addr1=0, wdata1=0xFFFFFFFF -> ack1=1, tube_we=0.
  - addr1=4, wdata1=0x0000000A -> tube_we=1, tube_wd=0x0000000A.
  - Without the macro, both writes assert tube_we.
